regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Arbitrates the single write port of the 4x8-bit register file between core write-back and a debug/loader port.
//  Core write-back has priority; a blocked debug write is force-granted by stalling the core for one cycle.
//  Sits between the control unit and the register file, driving regWrite/regAlvo/data. Read path untouched.
// PARAMETERS
//  STARVE_LIMIT  4  consecutive blocked debug cycles before a forced grant (>=1)
//  localparam CNT_W = $clog2(STARVE_LIMIT+1)  wait counter width (not overridable)
// PORTS
//  clock          in   1  system clock, all state on posedge
//  reset          in   1  synchronous, active-high
//  core_regWrite  in   1  core write-back enable
//  core_regAlvo   in   2  core destination register
//  core_data      in   8  core write-back value
//  dbg_valid      in   1  debug write request; held with addr/data until accepted
//  dbg_addr       in   2  debug destination register
//  dbg_data       in   8  debug write value
//  dbg_ready      out  1  debug write accepted this cycle (transfer = dbg_valid & dbg_ready)
//  stall_core     out  1  core must hold PC and write-back inputs this cycle
//  rf_regWrite    out  1  to register file regWrite
//  rf_regAlvo     out  2  to register file regAlvo (write address)
//  rf_data        out  8  to register file data
// BEHAVIOUR
//  - States: IDLE, WAIT, FORCE; wait_cnt[CNT_W-1:0]. Reset -> IDLE, wait_cnt=0.
//  - While reset=1: rf_regWrite=0, dbg_ready=0, stall_core=0 (other outputs don't-care).
//  - Outputs combinational from state + inputs; zero-latency grant.
//  - blocked = dbg_valid & core_regWrite & state!=FORCE.
//  - grant_dbg = dbg_valid & (!core_regWrite | state==FORCE); dbg_ready = grant_dbg.
//  - grant_dbg=1: rf_regWrite=1, rf_regAlvo=dbg_addr, rf_data=dbg_data.
//  - else: rf_regWrite=core_regWrite, rf_regAlvo=core_regAlvo, rf_data=core_data.
//  - stall_core=1 only in FORCE with dbg_valid=1; core write suppressed that cycle, retried next cycle.
//  - IDLE: blocked -> WAIT, wait_cnt=1 (STARVE_LIMIT==1: -> FORCE directly); otherwise stay, wait_cnt=0.
//  - WAIT: !dbg_valid -> IDLE, wait_cnt=0 (request withdrawn, nothing written).
//          grant_dbg -> IDLE, wait_cnt=0.
//          blocked & wait_cnt==STARVE_LIMIT-1 -> FORCE; blocked otherwise -> wait_cnt+1.
//  - FORCE: always -> IDLE, wait_cnt=0; grants debug if dbg_valid, else no stall.
//  - Worst-case debug latency: STARVE_LIMIT blocked cycles, grant in cycle STARVE_LIMIT.
//  - Core and debug never write in the same cycle; same-address conflicts resolve by grant order.
//  - Reset mid-WAIT/FORCE: pending request dropped, no write, counter cleared.
//  - wait_cnt never exceeds STARVE_LIMIT-1; no wrap.
// CONFIGURATION
//  ARB_STATS_EN defined: extra outputs force_count[7:0], dbg_writes[7:0].
//   force_count: cycles with stall_core=1; dbg_writes: accepted debug writes.
//   Both saturate at 8'hFF, clear on reset.
//  ARB_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset: reset=1, core_regWrite=1, dbg_valid=1 -> rf_regWrite=0, dbg_ready=0, stall_core=0; state IDLE after.
//  2 Idle grant: core_regWrite=0, dbg_valid=1, dbg_addr=2, dbg_data=8'h5A -> same-cycle dbg_ready=1; r2=8'h5A next edge.
//  3 Core priority: core writes r1=8'h11 each cycle, dbg_valid=1 (r1=8'h22), STARVE_LIMIT=4
//    -> dbg_ready=0 cycles 0-3, r1=8'h11; cycle 4 stall_core=1, dbg_ready=1, r1=8'h22; cycle 5 core retry r1=8'h11.
//  4 Gap grant: core writes cycles 0-1, idle cycle 2 -> debug granted cycle 2, stall_core never 1, wait_cnt back to 0.
//  5 Withdraw/reset: dbg_valid dropped in WAIT -> no debug write, IDLE; reset in FORCE -> no write, no stall.
//  6 ARB_STATS_EN: 300 forced grants -> force_count=8'hFF, dbg_writes=8'hFF; build without macro compiles, no stats ports.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 4x8 register file: core write-back first, debug force-granted after starvation.
// Optional ARB_STATS_EN adds saturating force_count / dbg_writes counters.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       core_regWrite,
    input  logic [1:0] core_regAlvo,
    input  logic [7:0] core_data,
    input  logic       dbg_valid,
    input  logic [1:0] dbg_addr,
    input  logic [7:0] dbg_data,
    output logic       dbg_ready,
    output logic       stall_core,
    output logic       rf_regWrite,
    output logic [1:0] rf_regAlvo,
    output logic [7:0] rf_data
`ifdef ARB_STATS_EN
    ,
    output logic [7:0] force_count,
    output logic [7:0] dbg_writes
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt, cnt_nxt;
    logic             in_force;
    logic             blocked;
    logic             grant_dbg;

    always_comb begin
        in_force    = (state == FORCE);
        blocked     = dbg_valid & core_regWrite & ~in_force;
        grant_dbg   = dbg_valid & (~core_regWrite | in_force) & ~reset;
        dbg_ready   = grant_dbg;
        stall_core  = in_force & dbg_valid & ~reset;
        rf_regWrite = ~reset & (grant_dbg | core_regWrite);
        rf_regAlvo  = grant_dbg ? dbg_addr : core_regAlvo;
        rf_data     = grant_dbg ? dbg_data : core_data;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (blocked) begin
                    if (STARVE_LIMIT == 1) begin
                        state_nxt = FORCE;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            WAIT: begin
                // Withdrawn or granted requests both fall out of !blocked here
                if (!blocked) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (wait_cnt == CNT_W'(STARVE_LIMIT - 1)) begin
                    state_nxt = FORCE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            FORCE: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= cnt_nxt;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            force_count <= '0;
            dbg_writes  <= '0;
        end else begin
            if (stall_core && force_count != 8'hFF)
                force_count <= force_count + 8'd1;
            if (grant_dbg && dbg_writes != 8'hFF)
                dbg_writes <= dbg_writes + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios then random traffic vs a starvation-count model.
// Stats checks are compiled in when ARB_STATS_EN is defined.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;

    logic       clock = 0;
    logic       reset;
    logic       core_regWrite;
    logic [1:0] core_regAlvo;
    logic [7:0] core_data;
    logic       dbg_valid;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    logic       dbg_ready;
    logic       stall_core;
    logic       rf_regWrite;
    logic [1:0] rf_regAlvo;
    logic [7:0] rf_data;
`ifdef ARB_STATS_EN
    logic [7:0] force_count;
    logic [7:0] dbg_writes;
`endif

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .core_regWrite(core_regWrite),
        .core_regAlvo(core_regAlvo),
        .core_data(core_data),
        .dbg_valid(dbg_valid),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .dbg_ready(dbg_ready),
        .stall_core(stall_core),
        .rf_regWrite(rf_regWrite),
        .rf_regAlvo(rf_regAlvo),
        .rf_data(rf_data)
`ifdef ARB_STATS_EN
        ,
        .force_count(force_count),
        .dbg_writes(dbg_writes)
`endif
    );

    always #5 clock = ~clock;

    // Register file fed by the DUT write port
    logic [7:0] tb_rf [4];
    always_ff @(posedge clock) begin
        if (rf_regWrite) tb_rf[rf_regAlvo] <= rf_data;
    end

    int         tests = 0;
    int         fails = 0;
    int         run = 0;
    bit         last_grant = 0;
    bit         last_stall = 0;
    logic [7:0] mrf [4];
    bit         mvalid [4] = '{0, 0, 0, 0};
    int         m_force = 0;
    int         m_dw = 0;

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, o, e);
        end
    endtask

    // One cycle: predict from the model, compare, clock, update the model
    task automatic step();
        bit         frc, g, st, we;
        logic [1:0] a;
        logic [7:0] d;
        #1;
        frc = (run == LIMIT);
        g   = !reset && dbg_valid && (!core_regWrite || frc);
        st  = !reset && frc && dbg_valid;
        we  = !reset && (g || core_regWrite);
        a   = g ? dbg_addr : core_regAlvo;
        d   = g ? dbg_data : core_data;
        chk("dbg_ready", dbg_ready, g);
        chk("stall_core", stall_core, st);
        chk("rf_regWrite", rf_regWrite, we);
        if (we) begin
            chk("rf_regAlvo", rf_regAlvo, a);
            chk("rf_data", rf_data, d);
        end
        @(posedge clock);
        if (we) begin
            mrf[a]    = d;
            mvalid[a] = 1;
        end
        if (reset || frc || !dbg_valid || g) run = 0;
        else run++;
        last_grant = g;
        last_stall = st;
        if (reset) begin
            m_force = 0;
            m_dw    = 0;
        end else begin
            if (st && m_force < 255) m_force++;
            if (g && m_dw < 255) m_dw++;
        end
        #1;
        for (int i = 0; i < 4; i++)
            if (mvalid[i]) chk($sformatf("rf[%0d]", i), tb_rf[i], mrf[i]);
`ifdef ARB_STATS_EN
        chk("force_count", force_count, m_force);
        chk("dbg_writes", dbg_writes, m_dw);
`endif
    endtask

    task automatic drive(bit r, bit cw, logic [1:0] ca, logic [7:0] cd,
                         bit dv, logic [1:0] da, logic [7:0] dd);
        reset = r;
        core_regWrite = cw;
        core_regAlvo = ca;
        core_data = cd;
        dbg_valid = dv;
        dbg_addr = da;
        dbg_data = dd;
    endtask

    initial begin
        // 1: reset masks everything
        drive(1, 1, 2'd3, 8'h33, 1, 2'd0, 8'h44);
        #1;
        chk("rst_we", rf_regWrite, 0);
        chk("rst_ready", dbg_ready, 0);
        chk("rst_stall", stall_core, 0);
        step();
        step();

        // 2: idle grant, zero latency
        drive(0, 0, 2'd0, 8'h00, 1, 2'd2, 8'h5A);
        #1;
        chk("idle_ready", dbg_ready, 1);
        step();
        chk("idle_r2", tb_rf[2], 8'h5A);

        // 3: core priority, forced grant in cycle LIMIT, core retry after
        for (int i = 0; i < LIMIT + 2; i++) begin
            drive(0, 1, 2'd1, 8'h11, (i <= LIMIT), 2'd1, 8'h22);
            #1;
            chk($sformatf("pri_ready%0d", i), dbg_ready, (i == LIMIT));
            chk($sformatf("pri_stall%0d", i), stall_core, (i == LIMIT));
            step();
            chk($sformatf("pri_r1_%0d", i), tb_rf[1],
                (i == LIMIT) ? 8'h22 : 8'h11);
        end

        // 4: gap grant without stalling
        for (int i = 0; i < 3; i++) begin
            drive(0, (i < 2), 2'd0, 8'hC0, 1, 2'd3, 8'h77);
            #1;
            chk($sformatf("gap_stall%0d", i), stall_core, 0);
            chk($sformatf("gap_ready%0d", i), dbg_ready, (i == 2));
            step();
        end
        chk("gap_r3", tb_rf[3], 8'h77);

        // 5a: withdraw while waiting
        drive(0, 1, 2'd0, 8'h01, 1, 2'd3, 8'hEE);
        step();
        step();
        drive(0, 0, 2'd0, 8'h01, 0, 2'd3, 8'hEE);
        step();
        chk("wd_r3", tb_rf[3], 8'h77);

        // 5b: reset while in FORCE
        drive(0, 1, 2'd0, 8'h02, 1, 2'd2, 8'h99);
        for (int i = 0; i < LIMIT; i++) step();
        reset = 1;
        #1;
        chk("frc_rst_we", rf_regWrite, 0);
        chk("frc_rst_stall", stall_core, 0);
        step();
        chk("frc_rst_r2", tb_rf[2], 8'h5A);

        // Random traffic obeying the hold rules
        for (int i = 0; i < 800; i++) begin
            reset = ($urandom_range(0, 60) == 0);
            if (!last_stall) begin
                core_regWrite = ($urandom_range(0, 3) != 0);
                core_regAlvo  = 2'($urandom_range(0, 3));
                core_data     = 8'($urandom);
            end
            if (dbg_valid && !last_grant) begin
                if ($urandom_range(0, 15) == 0) dbg_valid = 0;
            end else begin
                dbg_valid = $urandom_range(0, 1) != 0;
                dbg_addr  = 2'($urandom_range(0, 3));
                dbg_data  = 8'($urandom);
            end
            step();
        end

`ifdef ARB_STATS_EN
        // 6: counters saturate
        drive(1, 0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
        step();
        reset = 0;
        for (int k = 0; k < 300; k++) begin
            drive(0, 1, 2'd0, 8'h10, 1, 2'd1, 8'(k));
            for (int c = 0; c <= LIMIT; c++) step();
        end
        chk("sat_force", force_count, 8'hFF);
        chk("sat_dw", dbg_writes, 8'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
